// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: steps a shared-memory datapath through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control_fsm #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   i_or_d,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic [1:0]             pc_src,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [2:0]             alu_control,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   illegal_op,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t                   state_q, state_d;
  logic                     out_en;
  logic                     is_store_q, is_store_d;
  logic                     retire;
  logic                     funct_ok;
  logic                     op_legal;
  logic [2:0]               funct_alu;
  logic [COUNT_WIDTH-1:0]   count_q;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_RTYPE:                           op_legal = funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  // out_en holds everything quiet until the first edge after reset release,
  // and its async clear is what drops mem_write the instant reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      out_en     <= 1'b0;
      is_store_q <= 1'b0;
      count_q    <= '0;
    end else begin
      out_en     <= 1'b1;
      state_q    <= state_d;
      is_store_q <= is_store_d;
      if (retire) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    retire     = 1'b0;
    if (!out_en) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          is_store_d = (opcode == OP_SW);
          if (!op_legal)                           state_d = S_FETCH;
          else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
          else if (opcode == OP_RTYPE)             state_d = S_EXEC;
          else if (opcode == OP_BEQ)               state_d = S_BRANCH;
          else if (opcode == OP_ADDI)              state_d = S_ADDIEX;
          else                                     state_d = S_JUMP;
        end
        S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
        S_MEMWR:  if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
        S_EXEC:   state_d = S_ALUWB;
        S_ALUWB:  begin state_d = S_FETCH; retire = 1'b1; end
        S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
        S_ADDIEX: state_d = S_ADDIWB;
        S_ADDIWB: begin state_d = S_FETCH; retire = 1'b1; end
        S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    i_or_d        = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = '0;
    alu_control   = '0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    if (out_en && state_q <= S_JUMP) alu_control = 3'b010;
    if (out_en) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = ~op_legal;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = funct_alu;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_control   = 3'b110;
          pc_src        = 2'b01;
          pc_write_cond = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: expected per-cycle state,
// outputs and retire count are queued per instruction and checked cycle by cycle.
module tb_multicycle_control_fsm;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BRANCH, ADDIEX, ADDIWB, JUMP
  } st_t;

  typedef struct packed {
    logic       mem_req, i_or_d, mem_write, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op;
  } outs_t;

  typedef struct {
    st_t         st;
    logic        rdy;
    logic [31:0] cnt;
    logic [5:0]  op, fn;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, funct;
  logic mem_ready;

  logic mem_req, i_or_d, mem_write, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b;
  logic alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic [31:0] instr_count;

  logic mem_req4, i_or_d4, mem_write4, ir_write4, pc_write4, pc_write_cond4;
  logic [1:0] pc_src4, alu_src_b4;
  logic alu_src_a4, reg_dst4, mem_to_reg4, reg_write4, illegal_op4;
  logic [2:0] alu_control4;
  logic [3:0] state4;
  logic [3:0] instr_count4;

  multicycle_control_fsm #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  multicycle_control_fsm #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req4), .i_or_d(i_or_d4), .mem_write(mem_write4), .ir_write(ir_write4),
    .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .pc_src(pc_src4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_control(alu_control4),
    .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .reg_write(reg_write4),
    .illegal_op(illegal_op4), .state(state4), .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  outs_t g, g4;
  assign g  = {mem_req, i_or_d, mem_write, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write, illegal_op};
  assign g4 = {mem_req4, i_or_d4, mem_write4, ir_write4, pc_write4, pc_write_cond4, pc_src4,
               alu_src_a4, alu_src_b4, alu_control4, reg_dst4, mem_to_reg4, reg_write4, illegal_op4};

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mcnt = '0;
  int          id = 0;
  logic [5:0]  cur_op, cur_fn;

  function automatic logic legal(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00:                          return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      6'h23, 6'h2B, 6'h04, 6'h08, 6'h02: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic outs_t model(st_t s, logic rdy, logic [5:0] op, logic [5:0] fn);
    outs_t o;
    o = '0;
    o.alu_control = 3'b010;
    case (s)
      FETCH:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      DECODE: begin o.alu_src_b = 2'b11; o.illegal_op = !legal(op, fn); end
      MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      MEMRD:  begin o.mem_req = 1; o.i_or_d = 1; end
      MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      MEMWR:  begin o.mem_req = 1; o.i_or_d = 1; o.mem_write = 1; end
      EXEC:   begin o.alu_src_a = 1; o.alu_control = alu_of(fn); end
      ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
      BRANCH: begin o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_src = 2'b01; o.pc_write_cond = 1; end
      ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      ADDIWB: o.reg_write = 1;
      JUMP:   begin o.pc_src = 2'b10; o.pc_write = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(st_t s, logic r, logic ret);
    exp_t e;
    e.st = s; e.rdy = r; e.cnt = mcnt; e.op = cur_op; e.fn = cur_fn; e.id = id;
    q.push_back(e);
    if (ret) mcnt++;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic build(logic [5:0] op, logic [5:0] fn, int fw, int mw);
    cur_op = op; cur_fn = fn; id++;
    repeat (fw) push(FETCH, 1'b0, 1'b0);
    push(FETCH, 1'b1, 1'b0);
    push(DECODE, rb(), 1'b0);
    if (legal(op, fn)) begin
      case (op)
        6'h23: begin
          push(MEMADR, rb(), 1'b0);
          repeat (mw) push(MEMRD, 1'b0, 1'b0);
          push(MEMRD, 1'b1, 1'b0);
          push(MEMWB, rb(), 1'b1);
        end
        6'h2B: begin
          push(MEMADR, rb(), 1'b0);
          repeat (mw) push(MEMWR, 1'b0, 1'b0);
          push(MEMWR, 1'b1, 1'b1);
        end
        6'h00: begin push(EXEC, rb(), 1'b0); push(ALUWB, rb(), 1'b1); end
        6'h04: push(BRANCH, rb(), 1'b1);
        6'h08: begin push(ADDIEX, rb(), 1'b0); push(ADDIWB, rb(), 1'b1); end
        default: push(JUMP, rb(), 1'b1);
      endcase
    end
  endtask

  // opcode/funct are scrambled outside DECODE and EXEC to show they are ignored there
  task automatic drain(int n);
    exp_t  e;
    outs_t m;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      e = q.pop_front();
      mem_ready = e.rdy;
      if (e.st == DECODE || e.st == EXEC) begin
        opcode = e.op; funct = e.fn;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      #1;
      m = model(e.st, e.rdy, opcode, funct);
      chk($sformatf("i%0d_%s_state", e.id, e.st.name()), 32'(state), 32'(e.st));
      chk($sformatf("i%0d_%s_outs", e.id, e.st.name()), 32'(g), 32'(m));
      chk($sformatf("i%0d_%s_outs4", e.id, e.st.name()), 32'(g4), 32'(m));
      chk($sformatf("i%0d_%s_count", e.id, e.st.name()), instr_count, e.cnt);
      chk($sformatf("i%0d_%s_count4", e.id, e.st.name()), 32'(instr_count4), 32'(e.cnt[3:0]));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_release();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_hold_outs", 32'(g), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    #12;
    chk("reset_outs", 32'(g), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    do_release();

    build(6'h23, 6'h15, 0, 0);   // lw
    build(6'h2B, 6'h00, 0, 3);   // sw, 3 wait cycles in MEMWR
    build(6'h04, 6'h3F, 0, 0);   // beq
    build(6'h00, 6'h2A, 0, 0);   // slt
    build(6'h00, 6'h00, 0, 0);   // bad funct
    build(6'h08, 6'h11, 2, 0);   // addi with fetch wait
    build(6'h00, 6'h20, 1, 0);   // add
    build(6'h00, 6'h22, 0, 0);   // sub
    build(6'h00, 6'h24, 0, 0);   // and
    build(6'h00, 6'h25, 0, 0);   // or
    build(6'h3F, 6'h20, 0, 0);   // bad opcode
    build(6'h23, 6'h00, 1, 2);   // lw with waits
    drain(1000);

    // abort in MEMRD
    build(6'h23, 6'h00, 0, 5);
    drain(4);
    mem_ready = 1'b0;
    #1;
    chk("pre_reset_memrd", 32'(state), 32'(MEMRD));
    rst = 1'b0;
    #1;
    chk("memrd_reset_outs", 32'(g), 32'd0);
    chk("memrd_reset_state", 32'(state), 32'd0);
    chk("memrd_reset_count", instr_count, 32'd0);
    chk("memrd_reset_count4", 32'(instr_count4), 32'd0);
    q.delete();
    mcnt = '0;
    do_release();
    mem_ready = 1'b0;
    #1;
    chk("post_release_fetch", 32'(g), 32'(model(FETCH, 1'b0, 6'h00, 6'h00)));

    repeat (16) build(6'h02, 6'h00, 0, 0);
    drain(1000);
    chk("wrap_count4", 32'(instr_count4), 32'd0);
    chk("wrap_count32", instr_count, 32'd16);

    // abort in MEMWR: mem_write must fall without a clock edge
    build(6'h2B, 6'h00, 0, 5);
    drain(4);
    mem_ready = 1'b0;
    #1;
    chk("pre_reset_mem_write", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_mem_write_drop", 32'(mem_write), 32'd0);
    chk("async_mem_req_drop", 32'(mem_req), 32'd0);
    q.delete();
    mcnt = '0;
    do_release();
    chk("final_count", instr_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
